// File: rtl/env_slot_sequencer_pkg.sv
// Shared types and constants for the envelope slot sequencer.
// Holds the FSM state enum, the slot index struct and the frame geometry.
package synth_pkg;

  localparam int VOICES       = 32;
  localparam int V_ENVS       = 8;
  localparam int V_WIDTH      = 5;
  localparam int E_WIDTH      = 3;
  localparam int SLOT_W       = V_WIDTH + E_WIDTH;
  localparam int DEF_RD_LAT   = 2;
  localparam int DEF_PROC_LAT = 3;

  localparam int SLOTS_PER_FRAME = VOICES * V_ENVS;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    WAIT_ZERO = 2'd0,
    RUN       = 2'd1,
    DRAIN     = 2'd2
  } state_e;

  typedef struct packed {
    logic [V_WIDTH-1:0] voice;
    logic [E_WIDTH-1:0] env;
  } slot_t;

  typedef struct packed {
    logic  valid;
    slot_t slot;
  } pipe_t;

  // Slot index that should follow idx, wrapping at the end of the frame.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] idx);
    return (idx == LAST_SLOT) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/env_slot_sequencer_if.sv
// RAM-side strobe bundle of the envelope slot sequencer, plus FSM debug view.
interface env_slot_sequencer_if
  import synth_pkg::*;
();

  // Every strobe is a single-cycle valid with no ready: the envelope RAM and
  // processing stage must accept one slot per cycle, there is no back-pressure.
  logic                rd_en;
  logic [SLOT_W-1:0]   rd_addr;
  logic                proc_valid;
  logic [V_WIDTH-1:0]  proc_voice;
  logic [E_WIDTH-1:0]  proc_env;
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_addr;
  logic                frame_start;
  logic                frame_done;
  logic                seq_err;
  logic                locked;
  state_e              dbg_state;
  logic [SLOT_W-1:0]   dbg_exp;

  modport master (
    output rd_en, rd_addr, proc_valid, proc_voice, proc_env,
           wr_en, wr_addr, frame_start, frame_done, seq_err, locked,
           dbg_state, dbg_exp
  );

  modport slave (
    input  rd_en, rd_addr, proc_valid, proc_voice, proc_env,
           wr_en, wr_addr, frame_start, frame_done, seq_err, locked,
           dbg_state, dbg_exp
  );

endinterface

// File: rtl/env_slot_sequencer_slot_clk_sync.sv
// Brings the envelope slot clock into the audio clock domain and emits a
// single-cycle strobe three cycles after each source rising edge.
module slot_clk_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_slot_clk,
  output logic o_slot_stb
);

  logic r_meta;
  logic r_sync;
  logic r_edge;
  logic r_stb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_edge <= 1'b0;
      r_stb  <= 1'b0;
    end else begin
      r_meta <= i_slot_clk;
      r_sync <= r_meta;
      r_edge <= r_sync;
      r_stb  <= r_sync & ~r_edge;
    end
  end

  assign o_slot_stb = r_stb;

endmodule

// File: rtl/env_slot_sequencer.sv
// Envelope slot sequencer: turns slot-clock edges into read/process/write-back
// strobes for the envelope RAM. Optional macro ENV_SEQ_CHECK_EN adds index-sequence checking.
module env_slot_sequencer
  import synth_pkg::*;
#(
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int PROC_LAT = DEF_PROC_LAT
) (
  input  logic              AUDIO_CLK,
  input  logic              reset_reg,
  input  logic              enable,
  input  logic              sCLK_XVXENVS,
  input  logic [SLOT_W-1:0] xxxx,
  input  logic              xxxx_zero,
  input  logic              err_clr,
  env_slot_sequencer_if.master bus
);

  localparam int DEPTH = RD_LAT + PROC_LAT;

  logic              w_slot_stb;
  slot_t             w_idx;
  logic              w_idx_zero;
  logic              w_issue;
  logic              w_seq_mis;
  logic              w_err_set;
  logic              w_pipe_busy;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [SLOT_W-1:0] r_exp;
  logic              r_seq_err;
  pipe_t             r_pipe [DEPTH];

  slot_clk_sync u_slot_clk_sync (
    .i_clk      (AUDIO_CLK),
    .i_rst      (reset_reg),
    .i_slot_clk (sCLK_XVXENVS),
    .o_slot_stb (w_slot_stb)
  );

  // The index is held stable around the strobe, so it is sampled directly.
  assign w_idx      = slot_t'(xxxx);
  assign w_idx_zero = (xxxx == '0);

`ifdef ENV_SEQ_CHECK_EN
  assign w_seq_mis = w_slot_stb && (r_state == RUN) && (xxxx != r_exp);
`else
  assign w_seq_mis = 1'b0;
`endif

  assign w_err_set = (w_slot_stb && (xxxx_zero != w_idx_zero)) || w_seq_mis;

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[k].valid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      WAIT_ZERO: begin
        if (w_slot_stb && enable && w_idx_zero) begin
          w_issue     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_slot_stb) begin
          if (!enable || w_seq_mis) begin
            w_state_nxt = DRAIN;
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Strobes are ignored here; a fresh lock only starts from WAIT_ZERO.
        if (!w_pipe_busy) begin
          w_state_nxt = WAIT_ZERO;
        end
      end
      default: w_state_nxt = WAIT_ZERO;
    endcase
  end

  always_ff @(posedge AUDIO_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      r_state <= WAIT_ZERO;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_exp <= next_slot(xxxx);
      end
    end
  end

  always_ff @(posedge AUDIO_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      r_seq_err <= 1'b0;
    end else if (w_err_set) begin
      r_seq_err <= 1'b1;
    end else if (err_clr) begin
      r_seq_err <= 1'b0;
    end
  end

  // Fixed-latency slot pipeline; stage RD_LAT-1 is the processing point and
  // the last stage is write-back. Idle stages carry an all-zero slot.
  always_ff @(posedge AUDIO_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_issue;
      r_pipe[0].slot  <= w_issue ? w_idx : slot_t'('0);
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign bus.rd_en       = w_issue;
  assign bus.rd_addr     = w_issue ? xxxx : '0;
  assign bus.frame_start = w_issue && w_idx_zero;
  assign bus.proc_valid  = r_pipe[RD_LAT-1].valid;
  assign bus.proc_voice  = r_pipe[RD_LAT-1].slot.voice;
  assign bus.proc_env    = r_pipe[RD_LAT-1].slot.env;
  assign bus.wr_en       = r_pipe[DEPTH-1].valid;
  assign bus.wr_addr     = r_pipe[DEPTH-1].slot;
  assign bus.frame_done  = r_pipe[DEPTH-1].valid && (r_pipe[DEPTH-1].slot == LAST_SLOT);
  assign bus.seq_err     = r_seq_err;
  assign bus.locked      = (r_state == RUN);
  assign bus.dbg_state   = r_state;
  assign bus.dbg_exp     = r_exp;

endmodule

// File: tb/tb_env_slot_sequencer.sv
// Directed bench for env_slot_sequencer: table of slot vectors plus hand-written
// reset and error-clear sequences, with a write-back/process scoreboard.
module tb_env_slot_sequencer;
  import synth_pkg::*;

`ifdef ENV_SEQ_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  localparam int OP_SLOT = 0;
  localparam int OP_CLR  = 1;

  typedef struct {
    int         op;
    logic [7:0] idx;
    logic       zero;
    logic       en;
    logic       clr;
    logic       exp_issue;
    logic       exp_locked;
    logic       exp_err;
  } rec_t;

  logic       clk;
  logic       reset_reg;
  logic       enable;
  logic       sclk;
  logic [7:0] xxxx;
  logic       xxxx_zero;
  logic       err_clr;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         due_q[$];
  logic [7:0] pexp_q[$];
  int         pdue_q[$];
  rec_t       vecs[$];

  env_slot_sequencer_if bus ();

  env_slot_sequencer dut (
    .AUDIO_CLK    (clk),
    .reset_reg    (reset_reg),
    .enable       (enable),
    .sCLK_XVXENVS (sclk),
    .xxxx         (xxxx),
    .xxxx_zero    (xxxx_zero),
    .err_clr      (err_clr),
    .bus          (bus)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void add(input int op, input int idx, input logic zero, input logic en,
                              input logic clr, input logic iss, input logic lk, input logic er);
    rec_t r;
    r.op = op; r.idx = 8'(idx); r.zero = zero; r.en = en; r.clr = clr;
    r.exp_issue = iss; r.exp_locked = lk; r.exp_err = er;
    vecs.push_back(r);
  endfunction

  function automatic void flush_sb();
    exp_q.delete(); due_q.delete(); pexp_q.delete(); pdue_q.delete();
  endfunction

  task automatic check_idle(input string name);
    chk(name, {bus.rd_en, bus.rd_addr, bus.proc_valid, bus.proc_voice, bus.proc_env,
               bus.wr_en, bus.wr_addr, bus.frame_start, bus.frame_done, bus.seq_err,
               bus.locked}, 0);
  endtask

  // scoreboard: process and write-back strobes must appear exactly when due
  always @(negedge clk) begin
    if (pdue_q.size() > 0 && pdue_q[0] == cyc) begin
      chk("proc_valid", bus.proc_valid, 1);
      chk("proc_slot", {bus.proc_voice, bus.proc_env}, pexp_q[0]);
      void'(pdue_q.pop_front());
      void'(pexp_q.pop_front());
    end else begin
      chk("proc_valid idle", bus.proc_valid, 0);
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("wr_en", bus.wr_en, 1);
      chk("wr_addr", bus.wr_addr, exp_q[0]);
      chk("frame_done", bus.frame_done, exp_q[0] == 8'hFF);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("wr_en idle", bus.wr_en, 0);
      chk("frame_done idle", bus.frame_done, 0);
    end
  end

  // driver: one slot-clock period of 8 cycles, entered and left at posedge+1
  task automatic run_slot(input rec_t v);
    xxxx = v.idx; xxxx_zero = v.zero; enable = v.en; sclk = 1'b1;
    repeat (3) @(posedge clk);
    #1 err_clr = v.clr;
    @(negedge clk);
    chk("rd_en", bus.rd_en, v.exp_issue);
    chk("rd_addr", bus.rd_addr, v.exp_issue ? v.idx : 8'h00);
    chk("frame_start", bus.frame_start, v.exp_issue && (v.idx == 8'h00));
    if (v.exp_issue) begin
      pdue_q.push_back(cyc + 2); pexp_q.push_back(v.idx);
      due_q.push_back(cyc + 5);  exp_q.push_back(v.idx);
    end
    @(posedge clk);
    #1 err_clr = 1'b0; sclk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("locked", bus.locked, v.exp_locked);
    chk("seq_err", bus.seq_err, v.exp_err);
    chk("state", bus.dbg_state, v.exp_locked ? RUN : WAIT_ZERO);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr(input rec_t v);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("seq_err after clr", bus.seq_err, v.exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic mk_slot(input int idx, input logic zero, input logic iss, input logic lk,
                         input logic er, output rec_t r);
    r.op = OP_SLOT; r.idx = 8'(idx); r.zero = zero; r.en = 1'b1; r.clr = 1'b0;
    r.exp_issue = iss; r.exp_locked = lk; r.exp_err = er;
  endtask

  initial begin
    rec_t r;
    reset_reg = 1'b0; enable = 1'b0; sclk = 1'b0; xxxx = 8'd0; xxxx_zero = 1'b1; err_clr = 1'b0;

    // vector table
    add(OP_SLOT, 5, 0, 1, 0, 0, 0, 0);
    add(OP_SLOT, 0, 1, 1, 0, 1, 1, 0);
    for (int i = 1; i < 256; i++) add(OP_SLOT, i, 0, 1, 0, 1, 1, 0);
    add(OP_SLOT, 0, 0, 1, 0, 1, 1, 1);
    add(OP_SLOT, 1, 1, 1, 1, 1, 1, 1);
    add(OP_CLR,  0, 0, 1, 0, 0, 0, 0);
    add(OP_SLOT, 2, 0, 1, 0, 1, 1, 0);
    add(OP_SLOT, 4, 0, 1, 0, !CK, !CK, CK);
    add(OP_SLOT, 0, 1, 1, 0, 1, 1, CK);
    add(OP_CLR,  0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(OP_SLOT, i, 0, 1, 0, 1, 1, 0);
    add(OP_SLOT, 11, 0, 0, 0, 0, 0, 0);
    add(OP_SLOT, 12, 0, 1, 0, 0, 0, 0);

    // reset held while the slot clock toggles
    #2 reset_reg = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      repeat (4) @(posedge clk);
      #1 check_idle("reset held");
    end
    sclk = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_reg = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op == OP_CLR) pulse_clr(vecs[i]);
      else run_slot(vecs[i]);
    end

    // reset one cycle after the read strobe of slot 3
    mk_slot(0, 1, 1, 1, 0, r); run_slot(r);
    mk_slot(1, 0, 1, 1, 0, r); run_slot(r);
    mk_slot(2, 0, 1, 1, 0, r); run_slot(r);
    xxxx = 8'd3; xxxx_zero = 1'b0; enable = 1'b1; sclk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("slot3 rd_en", bus.rd_en, 1);
    chk("slot3 rd_addr", bus.rd_addr, 8'd3);
    @(posedge clk);
    #1 reset_reg = 1'b1; sclk = 1'b0;
    flush_sb();
    #1 check_idle("async reset outputs");
    chk("async reset state", bus.dbg_state, WAIT_ZERO);
    @(posedge clk);
    #1 reset_reg = 1'b0;
    repeat (8) @(posedge clk);
    #1 check_idle("after reset");

    // relock after reset
    mk_slot(0, 1, 1, 1, 0, r); run_slot(r);
    mk_slot(1, 0, 1, 1, 0, r); run_slot(r);

    repeat (8) @(posedge clk);
    #1 chk("scoreboard drained", due_q.size() + pdue_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/env_slot_sequencer.md
Name: env_slot_sequencer

Overview:
- Sits directly downstream of the synth clock generator and its voice/envelope index counter.
- Turns each rising edge of the envelope slot clock sCLK_XVXENVS, plus the current xxxx index, into a pipelined read / process / write-back strobe sequence on AUDIO_CLK for the envelope parameter RAM.
- Provides frame markers and a sticky index-sequence error so the envelope engine always runs locked to frame slot 0.

Parameters:
- VOICES, 32, voices per frame
- V_ENVS, 8, envelopes per voice
- V_WIDTH, 5, voice index width (clog2 VOICES)
- E_WIDTH, 3, envelope index width (clog2 V_ENVS)
- RD_LAT, 2, AUDIO_CLK cycles from rd_en to RAM data valid
- PROC_LAT, 3, AUDIO_CLK cycles from proc_valid to write-back

Ports:
- AUDIO_CLK, in, 1, system audio clock; all logic on its rising edge
- reset_reg, in, 1, asynchronous, active-high reset
- enable, in, 1, level; sequencer runs while high
- sCLK_XVXENVS, in, 1, envelope slot clock from the clock generator; asynchronous to AUDIO_CLK logic
- xxxx, in, V_WIDTH+E_WIDTH, slot index {voice, env}
- xxxx_zero, in, 1, high while xxxx==0 (informational; cross-checked)
- err_clr, in, 1, pulse; clears seq_err
- rd_en, out, 1, one-cycle RAM read strobe
- rd_addr, out, V_WIDTH+E_WIDTH, read address
- proc_valid, out, 1, one-cycle; RAM data valid for the slot
- proc_voice, out, V_WIDTH, voice field of the slot at proc_valid
- proc_env, out, E_WIDTH, envelope field of the slot at proc_valid
- wr_en, out, 1, one-cycle write-back strobe
- wr_addr, out, V_WIDTH+E_WIDTH, write-back address
- frame_start, out, 1, pulse with rd_en for index 0
- frame_done, out, 1, pulse with wr_en for index VOICES*V_ENVS-1
- seq_err, out, 1, sticky sequence error
- locked, out, 1, high in RUN

Behaviour:
- Reset: every output 0; FSM in WAIT_ZERO; pipeline cleared; expected index 0. Asserting reset mid-operation discards in-flight slots with no wr_en.
- Slot-clock synchronisation:
  - sCLK_XVXENVS passes through a 2-flop synchroniser plus one edge register.
  - slot_stb is high for 1 cycle, 3 AUDIO_CLK cycles after the source rising edge.
  - xxxx is captured on the slot_stb cycle. It is stable for at least 2 cycles before capture because the envelope divider is at least 4.
- FSM WAIT_ZERO:
  - Stays here on slot_stb with captured index ≠ 0, or while enable=0.
  - On slot_stb with index==0 and enable=1: go to RUN and issue the slot in the same cycle.
- FSM RUN:
  - Each slot_stb issues its slot: rd_en=1, rd_addr=captured index, frame_start=1 if index==0.
  - Expected index for the next slot = index+1, wrapping at VOICES*V_ENVS-1 back to 0.
  - enable=0 sampled on slot_stb: no issue; go to DRAIN.
- FSM DRAIN: stop issuing and complete in-flight slots; go to WAIT_ZERO when the pipeline is empty. An enable re-asserted during DRAIN takes effect only in WAIT_ZERO.
- Pipeline:
  - Shift register of (valid, index), depth RD_LAT+PROC_LAT.
  - proc_valid and proc_voice/proc_env fire exactly RD_LAT cycles after rd_en.
  - wr_en and wr_addr fire PROC_LAT cycles after proc_valid, i.e. RD_LAT+PROC_LAT cycles after rd_en.
  - Overlapping slots are legal; the pipeline is fully pipelined, with no stall.
- frame_done is coincident with wr_en for the last index.
- locked = (state==RUN).
- seq_err:
  - Set when err_clr and an error occur in the same cycle (set wins over clear); otherwise err_clr clears it.
  - xxxx_zero ≠ (captured index==0) at slot_stb also sets seq_err, without affecting state.

Optional Feature:
- ENV_SEQ_CHECK_EN defined:
  - In RUN, a slot_stb with captured index ≠ expected index sets seq_err.
  - That slot is not issued; the FSM goes to DRAIN then WAIT_ZERO (resync on the next index 0).
- ENV_SEQ_CHECK_EN undefined:
  - No expected-index comparison; every slot_stb in RUN is issued.
  - seq_err is driven only by the xxxx_zero cross-check.

Decomposition:
- Shared package synth_pkg holds:
  - the FSM state enum (WAIT_ZERO, RUN, DRAIN);
  - the slot_t struct {voice, env};
  - the constant SLOTS_PER_FRAME = VOICES*V_ENVS.
- One sub-module, slot_clk_sync: 2-flop synchroniser plus rising-edge detector for sCLK_XVXENVS, output slot_stb.

Test Plan:
- Reset held, slot clock toggling → all outputs 0. Release; first edge with xxxx=5 → no rd_en, locked=0. Edge with xxxx=0 → rd_en, rd_addr=0, frame_start=1, locked=1.
- Full frame of 256 slots, RD_LAT=2, PROC_LAT=3 → every wr_en exactly 5 cycles after its rd_en, wr_addr matching; frame_done with wr_addr=255.
- With ENV_SEQ_CHECK_EN, index sequence 0,1,2,4 → slot 4 not issued; seq_err=1; locked drops after slot 2 write-back. Next index 0 relocks. err_clr clears seq_err.
- enable deasserted after slot 10 → slots 0–10 complete with wr_en; no rd_en afterwards; state WAIT_ZERO.
- reset_reg pulsed 1 cycle after rd_en of slot 3 → no proc_valid/wr_en for slot 3; all outputs 0 immediately (asynchronous).
- xxxx=0 with xxxx_zero=0 at a strobe → seq_err=1; slot still issued.
